// File: rtl/apb_reg_pkg.sv
// rtl/apb_reg_pkg.sv - shared constants, types and helpers for the APB register bank
package apb_reg_pkg;

    // Parameter ceilings for the bank
    localparam int MAX_RW  = 64;
    localparam int MAX_RO  = 64;
    localparam int MAX_IRQ = 32;

    // Word index width covering the largest RW or RO array
    localparam int IDX_W = $clog2((MAX_RW > MAX_RO) ? MAX_RW : MAX_RO);

    // Register map offsets within the 1 KiB window
    localparam logic [9:0] RO_BASE        = 10'h100;
    localparam logic [9:0] IRQ_STATUS_OFS = 10'h200;
    localparam logic [9:0] IRQ_ENABLE_OFS = 10'h204;
    localparam logic [9:0] IRQ_RAW_OFS    = 10'h208;

    // Transfer FSM: RESP is the single wait-state-terminating cycle
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } apb_state_e;

    // Expand the four byte strobes into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/apb_irq_ctrl.sv
// rtl/apb_irq_ctrl.sv - rising-edge interrupt status with W1C clear, enable mask and level output
module apb_irq_ctrl #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_event,
    input  logic             status_wr,
    input  logic             enable_wr,
    input  logic [N_IRQ-1:0] wr_mask,
    input  logic [N_IRQ-1:0] wdata,
    output logic [N_IRQ-1:0] status,
    output logic [N_IRQ-1:0] enable,
    output logic             irq
);

    logic [N_IRQ-1:0] ev_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;

    // Rising edges and the W1C clear mask for this cycle
    always_comb begin
        rise = irq_event & ~ev_d;
        clr  = status_wr ? (wdata & wr_mask) : '0;
    end

    // Delay the sources by one cycle for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_d <= '0;
        end else begin
            ev_d <= irq_event;
        end
    end

    // Status bits: a rise in the same cycle as a clear keeps the bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= '0;
        end else begin
            status <= (status & ~clr) | rise;
        end
    end

    // Enable mask with byte-strobed writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= '0;
        end else if (enable_wr) begin
            enable <= (enable & ~wr_mask) | (wdata & wr_mask);
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status & enable);
        end
    end

endmodule

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB4 register bank with RW/RO arrays, W1C interrupts and one wait state
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int                  N_RW     = 16,
    parameter int                  N_RO     = 4,
    parameter int                  N_IRQ    = 8,
    parameter int                  ADDR_W   = 20,
    parameter logic [N_RW*32-1:0]  RW_RESET = '0
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic [ADDR_W-1:0]   I_apb_paddr,
    input  logic                I_apb_psel,
    input  logic                I_apb_penable,
    input  logic                I_apb_pwrite,
    input  logic [31:0]         I_apb_pwdata,
    input  logic [3:0]          I_apb_pstrb,
    output logic                O_apb_pready,
    output logic [31:0]         O_apb_prdata,
    output logic                O_apb_pslverr,
    output logic                O_apb_int,
    output logic [N_RW*32-1:0]  O_rw_regs,
    output logic [N_RW-1:0]     O_wr_pulse,
    input  logic [N_RO*32-1:0]  I_ro_regs,
    input  logic [N_IRQ-1:0]    I_irq_event
);

    apb_state_e state_q;
    apb_state_e state_d;

    logic [31:0]      rw_q [N_RW];
    logic [9:0]       offset;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wmask;
    logic             access;
    logic             wr_commit;
    logic             aligned;
    logic             rw_hit;
    logic             ro_hit;
    logic             st_hit;
    logic             en_hit;
    logic             raw_hit;
    logic             err;
    logic [31:0]      rdata;
    logic [N_IRQ-1:0] irq_status;
    logic [N_IRQ-1:0] irq_enable;
    logic [MAX_IRQ-1:0] status_word;
    logic [MAX_IRQ-1:0] enable_word;
    logic [MAX_IRQ-1:0] raw_word;
    logic             unused_paddr;

    // Upper address bits are decoded upstream by the bridge via psel
    assign unused_paddr = ^I_apb_paddr[ADDR_W-1:10];

    assign offset    = I_apb_paddr[9:0];
    assign idx       = offset[2 +: IDX_W];
    assign wmask     = lane_mask(I_apb_pstrb);
    assign access    = I_apb_psel & I_apb_penable & (state_q == IDLE);
    assign wr_commit = access & I_apb_pwrite & ~err;

    // Address decode and error classification
    always_comb begin
        aligned = (offset[1:0] == 2'b00);
        rw_hit  = (offset[9:8] == 2'b00) && (int'(idx) < N_RW);
        ro_hit  = (offset[9:8] == RO_BASE[9:8]) && (int'(idx) < N_RO);
        st_hit  = (offset == IRQ_STATUS_OFS);
        en_hit  = (offset == IRQ_ENABLE_OFS);
        raw_hit = (offset == IRQ_RAW_OFS);
        err     = !aligned
                  || !(rw_hit || ro_hit || st_hit || en_hit || raw_hit)
                  || (I_apb_pwrite && (ro_hit || raw_hit));
    end

    // Zero-extend the interrupt vectors to a full data word
    always_comb begin
        status_word = '0;
        enable_word = '0;
        raw_word    = '0;
        status_word[N_IRQ-1:0] = irq_status;
        enable_word[N_IRQ-1:0] = irq_enable;
        raw_word[N_IRQ-1:0]    = I_irq_event;
    end

    // Read multiplexer over all mapped registers
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_RW; i++) begin
            if (rw_hit && idx == IDX_W'(i)) begin
                rdata = rw_q[i];
            end
        end
        for (int j = 0; j < N_RO; j++) begin
            if (ro_hit && idx == IDX_W'(j)) begin
                rdata = I_ro_regs[32*j +: 32];
            end
        end
        if (st_hit) begin
            rdata = status_word;
        end
        if (en_hit) begin
            rdata = enable_word;
        end
        if (raw_hit) begin
            rdata = raw_word;
        end
    end

    // FSM state register
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: every access gets exactly one RESP cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (I_apb_psel && I_apb_penable) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: ready only in RESP
    always_comb begin
        O_apb_pready = (state_q == RESP);
    end

    // Response data and error, captured at the end of the first access cycle
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_apb_prdata  <= '0;
            O_apb_pslverr <= 1'b0;
        end else if (access) begin
            O_apb_pslverr <= err;
            if (err) begin
                O_apb_prdata <= '0;
            end else if (!I_apb_pwrite) begin
                O_apb_prdata <= rdata;
            end
        end else begin
            O_apb_pslverr <= 1'b0;
        end
    end

    // RW register array with byte-lane writes
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            for (int i = 0; i < N_RW; i++) begin
                rw_q[i] <= RW_RESET[32*i +: 32];
            end
        end else if (wr_commit && rw_hit) begin
            for (int i = 0; i < N_RW; i++) begin
                if (idx == IDX_W'(i)) begin
                    rw_q[i] <= (rw_q[i] & ~wmask) | (I_apb_pwdata & wmask);
                end
            end
        end
    end

    // One-cycle write notification, aligned with the response cycle
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < N_RW; i++) begin
                O_wr_pulse[i] <= wr_commit && rw_hit && (idx == IDX_W'(i));
            end
        end
    end

    for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
        assign O_rw_regs[32*g +: 32] = rw_q[g];
    end

    apb_irq_ctrl #(
        .N_IRQ (N_IRQ)
    ) u_irq (
        .clk       (I_clk),
        .rst       (I_rst),
        .irq_event (I_irq_event),
        .status_wr (wr_commit & st_hit),
        .enable_wr (wr_commit & en_hit),
        .wr_mask   (wmask[N_IRQ-1:0]),
        .wdata     (I_apb_pwdata[N_IRQ-1:0]),
        .status    (irq_status),
        .enable    (irq_enable),
        .irq       (O_apb_int)
    );

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB4 slave register bank for the PL control plane: N_RW read/write control registers with byte strobes, N_RO read-only status inputs, and a W1C interrupt block driving the APB interrupt line. Sits between the PS APB bridge and the camera/ISP/HDMI datapath, replacing fixed-count banks. Every transfer gets exactly one wait state. Unmapped or illegal accesses return PSLVERR instead of being silently ignored.

## Interface
- N_RW, default 16: read/write registers, 1..64.
- N_RO, default 4: read-only registers, 1..64.
- N_IRQ, default 8: interrupt sources, 1..32.
- ADDR_W, default 20: APB address width.
- RW_RESET, default all-zero: flat N_RW*32 reset values.
- I_clk  in  1  single clock.
- I_rst  in  1  asynchronous, active-high reset.
- I_apb_paddr  in  ADDR_W  byte address; bits [9:0] decoded, upper bits already decoded by the bridge via psel.
- I_apb_psel, I_apb_penable, I_apb_pwrite  in  1  APB control.
- I_apb_pwdata  in  32  write data.
- I_apb_pstrb  in  4  byte write strobes.
- O_apb_pready  out  1  transfer complete.
- O_apb_prdata  out  32  read data.
- O_apb_pslverr  out  1  error response.
- O_apb_int  out  1  level interrupt.
- O_rw_regs  out  N_RW*32  flat RW register contents; register i at [32i+31:32i].
- O_wr_pulse  out  N_RW  one-cycle pulse when RW register i is written.
- I_ro_regs  in  N_RO*32  flat read-only values.
- I_irq_event  in  N_IRQ  interrupt sources; a rising edge sets status.

## Operation
- Map, offset = paddr[9:0]:
  - RW i at 0x000+4i.
  - RO j at 0x100+4j.
  - IRQ_STATUS at 0x200, W1C.
  - IRQ_ENABLE at 0x204, RW.
  - IRQ_RAW at 0x208, RO: current I_irq_event.
- Error conditions, flagged with PSLVERR=1 and no state change:
  - paddr[1:0]≠0.
  - Offset outside the map.
  - Write to any RO or IRQ_RAW address.
- Read data on error: prdata=0.
- Writes: per byte lane k, register bytes update only where pstrb[k]=1.
  - IRQ_STATUS: bit b clears where pwdata[b]=1 and its byte strobe is set.
  - Bits ≥ N_IRQ read 0 and ignore writes.
- FSM states IDLE and RESP:
  - IDLE→RESP on psel&penable.
  - RESP→IDLE unconditionally.
  - RESP is the only state with pready=1.
- IRQ:
  - ev_d <= I_irq_event.
  - status |= I_irq_event & ~ev_d.
  - O_apb_int <= |(status & enable), registered.
  - Rising edge and W1C clear on the same bit in the same cycle: set wins.

## Timing
- Reset values: pready=0, prdata=0, pslverr=0, int=0, O_wr_pulse=0, O_rw_regs=RW_RESET, status=0, enable=0, ev_d=0, FSM=IDLE.
- Transfer cycles: setup cycle S, access cycles A0 and A1.
- Edge ending A0:
  - Write commits.
  - prdata and pslverr are registered.
  - pready <= 1.
  - O_wr_pulse[i] <= 1.
- During A1:
  - pready=1.
  - prdata and pslverr valid.
  - O_rw_regs already shows the new value.
  - O_wr_pulse asserted for one cycle.
- Edge ending A1: pready and pslverr return to 0; prdata holds its last value.
- Read-after-write back-to-back returns the new value.
- Interrupt latency: event rise at edge n → status set at n+1 → O_apb_int at n+2. A W1C in A0 deasserts int one cycle after A1 unless an event re-sets it.
- Reset asserted mid-transfer: FSM returns to IDLE and pready=0 immediately. The transfer is lost; the master must retry.
- A psel drop during RESP is still a completed transfer; no effect on committed state.

## Structure
- Shared package apb_reg_pkg:
  - Offsets RO_BASE=10'h100, IRQ_STATUS_OFS=10'h200, IRQ_ENABLE_OFS=10'h204, IRQ_RAW_OFS=10'h208.
  - FSM state constants IDLE/RESP.
  - Width limits.
- Sub-module apb_irq_ctrl holds edge detect, status, enable and int generation. Ports: event in, W1C/enable write strobes and data in, status/enable/int out.
- Top level holds decode, FSM, RW array and read mux.

## Test plan
- Reset with RW_RESET[0]=0x1234_5678: read 0x000 → 0x12345678, pslverr=0, pready high only in A1.
- Write 0xAABBCCDD to 0x004 with pstrb=4'b0101: reg1 = 0x00BB00DD, O_wr_pulse[1] pulses in A1; immediate readback matches.
- Write to 0x100, read 0x3FC, read 0x002: each gives pslverr=1 and prdata=0, with no register change.
- enable=0x01, pulse I_irq_event[0]: int rises two edges later; W1C 0x01 to 0x200 drops it; simultaneous event plus W1C leaves status[0]=1.
- Assert I_rst during A0 of a write to 0x008: reg2 = reset value, pready=0. A subsequent transfer completes normally.
